// File: rtl/rvfi_commit_checker.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_commit_checker
// Purpose  : RVFI commit-stream checker. Enforces prefix-packed, in-order,
//            gap-free commits across CHANNELS slots, detects halt and
//            post-halt activity, runs a no-commit watchdog and measures
//            instruction/cycle counts between start and stop markers.
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_commit_checker #(
  parameter int CHANNELS = 2,
  parameter int ORDER_W  = 64,
  parameter int CNT_W    = 48,
  parameter int TIMEOUT  = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         valid_i,
  input  logic [CHANNELS*ORDER_W-1:0] order_i,
  input  logic [CHANNELS*32-1:0]      inst_i,
  input  logic [CHANNELS*32-1:0]      pc_rdata_i,
  input  logic [CHANNELS*32-1:0]      pc_wdata_i,
  output logic                        halt_o,
  output logic                        error_o,
  output logic [3:0]                  errcode_o,
  output logic [ORDER_W-1:0]          expected_order_o,
  output logic                        seg_active_o,
  output logic                        seg_done_o,
  output logic [CNT_W-1:0]            seg_inst_o,
  output logic [CNT_W-1:0]            seg_cycle_o
);

  localparam int              WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX     = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [31:0] INST_BEQ_SELF = 32'h0000_0063;
  localparam logic [31:0] INST_JAL_SELF = 32'h0000_006F;
  localparam logic [31:0] INST_HALT     = 32'hF000_2013;
  localparam logic [31:0] INST_START    = 32'h0010_2013;
  localparam logic [31:0] INST_STOP     = 32'h0020_2013;

  localparam logic [3:0] ERR_GAP       = 4'd1;
  localparam logic [3:0] ERR_ORDER     = 4'd2;
  localparam logic [3:0] ERR_POST_HALT = 4'd3;
  localparam logic [3:0] ERR_TIMEOUT   = 4'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SEG    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e             state_q;
  logic               halt_q;
  logic               seg_active_q;
  logic [ORDER_W-1:0] expected_order_q;
  logic               error_q;
  logic [3:0]         errcode_q;
  logic               seg_done_q;
  logic [CNT_W-1:0]   seg_inst_q,  seg_inst_d;
  logic [CNT_W-1:0]   seg_cycle_q, seg_cycle_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   inst_cnt_q,  inst_cnt_d;
  logic [WD_W-1:0]    wd_q,        wd_d;

  logic [CHANNELS-1:0] valid_p1;
  logic                gap_err;
  logic                order_err;
  logic                post_halt;
  logic                timeout_err;
  logic                halt_seen;
  logic                seg_open;
  logic                started;
  logic                stop_hit;
  logic [ORDER_W-1:0]  rank;
  logic [CNT_W-1:0]    cc;
  logic [CNT_W-1:0]    ic;
  logic                err_any;
  logic [3:0]          err_code;

  // A legal valid vector is a run of ones from bit 0, so adding one clears it.
  assign valid_p1 = valid_i + 1'b1;
  assign gap_err  = |(valid_i & valid_p1);

  // Walk the channels in index order: order check, halt scan, counters, markers.
  always_comb begin
    rank        = '0;
    order_err   = 1'b0;
    halt_seen   = 1'b0;
    post_halt   = 1'b0;
    seg_open    = (state_q == ST_SEG);
    started     = 1'b0;
    stop_hit    = 1'b0;
    cc          = cycle_cnt_q;
    ic          = inst_cnt_q;
    seg_inst_d  = seg_inst_q;
    seg_cycle_d = seg_cycle_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (valid_i[c]) begin
        if (order_i[c*ORDER_W +: ORDER_W] != expected_order_q + rank) begin
          order_err = 1'b1;
        end
        rank = rank + 1'b1;
        // Anything committing after a halt (same cycle or later) is illegal.
        if (halt_seen || (state_q == ST_HALTED)) begin
          post_halt = 1'b1;
        end
        if ((pc_rdata_i[c*32 +: 32] == pc_wdata_i[c*32 +: 32]) ||
            (inst_i[c*32 +: 32] == INST_BEQ_SELF) ||
            (inst_i[c*32 +: 32] == INST_JAL_SELF) ||
            (inst_i[c*32 +: 32] == INST_HALT)) begin
          halt_seen = 1'b1;
        end
        if (ic != CNT_MAX) begin
          ic = ic + 1'b1;
        end
        if (state_q != ST_HALTED) begin
          if (inst_i[c*32 +: 32] == INST_START) begin
            // Only commits after the marker belong to the new segment.
            started  = 1'b1;
            seg_open = 1'b1;
            cc       = '0;
            ic       = '0;
          end else if ((inst_i[c*32 +: 32] == INST_STOP) && seg_open) begin
            seg_open    = 1'b0;
            stop_hit    = 1'b1;
            seg_inst_d  = ic;
            seg_cycle_d = (cc == CNT_MAX) ? cc : cc + 1'b1;
          end
        end
      end
    end
    inst_cnt_d = ic;
    if (started) begin
      cycle_cnt_d = '0;
    end else if (cycle_cnt_q != CNT_MAX) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end
  end

  // Watchdog next value and first-error arbitration (lowest code wins).
  always_comb begin
    wd_d        = wd_q;
    timeout_err = 1'b0;
    if (|valid_i) begin
      wd_d = '0;
    end else if (state_q != ST_HALTED) begin
      if (wd_q != WD_MAX) begin
        wd_d = wd_q + 1'b1;
      end
      timeout_err = (wd_q == WD_LAST);
    end
    err_any  = gap_err | order_err | post_halt | timeout_err;
    err_code = 4'd0;
    if (gap_err) begin
      err_code = ERR_GAP;
    end else if (order_err) begin
      err_code = ERR_ORDER;
    end else if (post_halt) begin
      err_code = ERR_POST_HALT;
    end else if (timeout_err) begin
      err_code = ERR_TIMEOUT;
    end
  end

  // Control FSM with its registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      halt_q       <= 1'b0;
      seg_active_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_SEG: begin
          if (halt_seen) begin
            state_q      <= ST_HALTED;
            halt_q       <= 1'b1;
            seg_active_q <= 1'b0;
          end else if (seg_open) begin
            state_q      <= ST_SEG;
            seg_active_q <= 1'b1;
          end else begin
            state_q      <= ST_RUN;
            seg_active_q <= 1'b0;
          end
        end
        ST_HALTED: begin
          state_q      <= ST_HALTED;
          halt_q       <= 1'b1;
          seg_active_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_RUN;
          halt_q       <= 1'b0;
          seg_active_q <= 1'b0;
        end
      endcase
    end
  end

  // Order tracking, counters, watchdog, sticky error and segment results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_order_q <= '0;
      error_q          <= 1'b0;
      errcode_q        <= 4'd0;
      seg_done_q       <= 1'b0;
      seg_inst_q       <= '0;
      seg_cycle_q      <= '0;
      cycle_cnt_q      <= '0;
      inst_cnt_q       <= '0;
      wd_q             <= '0;
    end else begin
      expected_order_q <= expected_order_q + rank;
      if (!error_q && err_any) begin
        error_q   <= 1'b1;
        errcode_q <= err_code;
      end
      seg_done_q  <= stop_hit;
      seg_inst_q  <= seg_inst_d;
      seg_cycle_q <= seg_cycle_d;
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
      wd_q        <= wd_d;
    end
  end

  assign halt_o           = halt_q;
  assign error_o          = error_q;
  assign errcode_o        = errcode_q;
  assign expected_order_o = expected_order_q;
  assign seg_active_o     = seg_active_q;
  assign seg_done_o       = seg_done_q;
  assign seg_inst_o       = seg_inst_q;
  assign seg_cycle_o      = seg_cycle_q;

endmodule
`default_nettype wire
